// File: rtl/serial_add_sequencer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | serial_add_sequencer_pkg                                           |
// | Shared constants and FSM encoding for the serial adder sequencer.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package serial_add_sequencer_pkg;

  localparam int DEF_WIDTH      = 8;
  localparam int DEF_FIFO_DEPTH = 2;
  localparam int DEF_LATENCY    = 9;

  // Latency countdown must hold LATENCY itself, hence the extra bit.
  localparam int COUNT_W = $clog2(DEF_LATENCY) + 1;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_RUN  = 3'd2;
  localparam logic [2:0] ST_CAPT = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  typedef enum logic [2:0] {
    IDLE = ST_IDLE,
    LOAD = ST_LOAD,
    RUN  = ST_RUN,
    CAPT = ST_CAPT,
    DONE = ST_DONE
  } state_t;

endpackage
`default_nettype wire

// File: rtl/serial_add_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | serial_add_fifo                                                    |
// | Small synchronous FIFO holding operand pairs; async active-low     |
// | reset. DEPTH must be a power of two so the pointers wrap freely.   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module serial_add_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [DATA_W-1:0]      push_data,
  input  logic                   pop,
  output logic [DATA_W-1:0]      pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full     = (count == (PTR_W + 1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  // Storage, pointers and occupancy; a same-edge push and pop leaves count alone.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (!do_push && do_pop) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/serial_add_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | serial_add_sequencer                                               |
// | Feeds operand pairs to a fixed-latency serial adder and collects   |
// | sum/carry onto a valid/ready result port. The adder's active-high  |
// | reset is expected to be driven from ~reset at integration.         |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module serial_add_sequencer
  import serial_add_sequencer_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int LATENCY    = DEF_LATENCY
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            in_a,
  input  logic [WIDTH-1:0]            in_b,
  output logic                        add_load,
  output logic [WIDTH-1:0]            add_a,
  output logic [WIDTH-1:0]            add_b,
  input  logic [WIDTH-1:0]            add_sum,
  input  logic                        add_carry,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WIDTH-1:0]            out_sum,
  output logic                        out_carry,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int CNT_W = $clog2(LATENCY) + 1;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push;
  logic               pop;
  logic [2*WIDTH-1:0] head;

  assign in_ready = ~fifo_full;
  assign push     = in_valid & in_ready;
  // Pops only happen on the two transitions that enter LOAD, so the adder
  // never receives a new pair while a result is in flight or unaccepted.
  assign pop      = ~fifo_empty &
                    ((state == IDLE) | ((state == DONE) & out_ready));

  serial_add_fifo #(
    .DATA_W (2 * WIDTH),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({in_a, in_b}),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Sequencer FSM with all adder-facing and result outputs registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      add_load  <= 1'b0;
      add_a     <= '0;
      add_b     <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_carry <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            {add_a, add_b} <= head;
            add_load       <= 1'b1;
            busy           <= 1'b1;
            state          <= LOAD;
          end
        end
        LOAD: begin
          add_load <= 1'b0;
          cnt      <= CNT_W'(LATENCY);
          state    <= RUN;
        end
        RUN: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            state <= CAPT;
          end
        end
        CAPT: begin
          out_sum   <= add_sum;
          out_carry <= add_carry;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (!fifo_empty) begin
              {add_a, add_b} <= head;
              add_load       <= 1'b1;
              state          <= LOAD;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
        end
        default: begin
          add_load  <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_add_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------+
// | tb_serial_add_sequencer                                            |
// | Directed bench with a behavioural 9-cycle adder model and a        |
// | queue-based result scoreboard.                                     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_serial_add_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_a = 8'h00;
  logic [7:0] in_b = 8'h00;
  logic       add_load;
  logic [7:0] add_a;
  logic [7:0] add_b;
  logic [7:0] add_sum;
  logic       add_carry;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_sum;
  logic       out_carry;
  logic       busy;
  logic [1:0] fifo_count;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int last_out_cyc = 0;
  int prev_out_cyc = 0;
  logic [8:0] exp_q[$];
  logic [8:0] mon_e;
  logic       prev_load = 1'b0;

  logic [7:0] m_a;
  logic [7:0] m_b;
  int         m_cnt = 0;

  serial_add_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .add_load   (add_load),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_sum    (add_sum),
    .add_carry  (add_carry),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sum    (out_sum),
    .out_carry  (out_carry),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Adder model: junk on the outputs until 9 edges after the load is sampled.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_cnt     <= 0;
      add_sum   <= 8'h00;
      add_carry <= 1'b0;
    end else if (add_load) begin
      m_a       <= add_a;
      m_b       <= add_b;
      m_cnt     <= 9;
      add_sum   <= 8'hA5;
      add_carry <= 1'b1;
    end else if (m_cnt > 1) begin
      m_cnt     <= m_cnt - 1;
      add_sum   <= add_sum ^ 8'h5B;
      add_carry <= ~add_carry;
    end else if (m_cnt == 1) begin
      m_cnt                <= 0;
      {add_carry, add_sum} <= {1'b0, m_a} + {1'b0, m_b};
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: scoreboard results and police the load pulse.
  always @(negedge clk) begin
    if (reset) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", {23'd0, out_carry, out_sum}, 32'h1FF);
        end else begin
          mon_e = exp_q.pop_front();
          check("result", {23'd0, out_carry, out_sum}, {23'd0, mon_e});
        end
        prev_out_cyc = last_out_cyc;
        last_out_cyc = cyc;
      end
      if (add_load) begin
        check("load_while_in_flight", m_cnt, 0);
        check("load_pulse_width", {31'd0, prev_load}, 0);
      end
    end
    prev_load = add_load;
  end

  task automatic push(input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] es, input logic ec);
    int k;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    k        = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!in_ready && k < 300);
    if (!in_ready) begin
      check("push_timeout", {31'd0, in_ready}, 1);
      in_valid = 1'b0;
    end else begin
      exp_q.push_back({ec, es});
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((busy || out_valid || fifo_count != 2'd0) && k < 500) begin
      @(negedge clk);
      k++;
    end
    check("drain_timeout", {31'd0, (busy || out_valid || fifo_count != 2'd0)}, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   k;
    logic stable;
    logic seen;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_add_load", {31'd0, add_load}, 0);
    check("rst_add_ab", {16'd0, add_a, add_b}, 0);
    check("rst_out", {22'd0, out_valid, out_carry, out_sum}, 0);
    check("rst_busy_count", {29'd0, busy, fifo_count}, 0);
    check("rst_in_ready", {31'd0, in_ready}, 1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Single addition: latency and load timing
    out_ready = 1'b1;
    push(8'h3C, 8'h5A, 8'h96, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    check("t1_count_after_push", {30'd0, fifo_count}, 1);
    @(negedge clk);
    check("t1_load_high", {31'd0, add_load}, 1);
    check("t1_add_ab", {16'd0, add_a, add_b}, 32'h3C5A);
    @(negedge clk);
    check("t1_load_low", {31'd0, add_load}, 0);
    check("t1_busy", {31'd0, busy}, 1);
    repeat (9) @(negedge clk);
    check("t1_valid_early", {31'd0, out_valid}, 0);
    @(negedge clk);
    check("t1_valid_on_time", {31'd0, out_valid}, 1);
    wait_idle();

    // Carry cases back-to-back
    push(8'hFF, 8'h01, 8'h00, 1'b1);
    push(8'hFF, 8'hFF, 8'hFE, 1'b1);
    in_valid = 1'b0;
    wait_idle();
    check("t2_result_gap", last_out_cyc - prev_out_cyc, 12);

    // Backpressure: result held, FIFO fills
    out_ready = 1'b0;
    push(8'h01, 8'h02, 8'h03, 1'b0);
    push(8'h03, 8'h04, 8'h07, 1'b0);
    push(8'h05, 8'h06, 8'h0B, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    check("t3_fifo_full", {29'd0, fifo_count, in_ready}, {29'd0, 2'd2, 1'b0});
    k = 0;
    while (!out_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("t3_result_ready", {31'd0, out_valid}, 1);
    stable = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (!(out_valid && out_sum == 8'h03 && !out_carry && !in_ready && !add_load))
        stable = 1'b0;
    end
    check("t3_hold_stable", {31'd0, stable}, 1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_idle();
    check("t3_queue_empty", exp_q.size(), 0);

    // Reset in the middle of RUN with one entry queued
    push(8'h11, 8'h22, 8'h33, 1'b0);
    push(8'h44, 8'h55, 8'h99, 1'b0);
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("t4_pre_busy_count", {29'd0, busy, fifo_count}, {29'd0, 1'b1, 2'd1});
    reset = 1'b0;
    exp_q.delete();
    #1;
    check("t4_async_load_ab", {15'd0, add_load, add_a, add_b}, 0);
    check("t4_async_out", {22'd0, out_valid, out_carry, out_sum}, 0);
    check("t4_async_busy_count", {28'd0, busy, fifo_count, in_ready}, 1);
    @(negedge clk);
    reset = 1'b1;
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid || add_load || busy) seen = 1'b1;
    end
    check("t4_no_ghost_result", {31'd0, seen}, 0);
    @(posedge clk);
    #1;

    // Simultaneous push/pop and push held while full
    out_ready = 1'b0;
    push(8'h10, 8'h20, 8'h30, 1'b0);
    push(8'h80, 8'h80, 8'h00, 1'b1);
    in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("t5_result_ready", {31'd0, out_valid}, 1);
    @(posedge clk);
    #1;
    check("t5_count_before", {30'd0, fifo_count}, 1);
    out_ready = 1'b1;
    push(8'h7F, 8'h01, 8'h80, 1'b0);
    check("t5_count_same_edge", {30'd0, fifo_count}, 1);
    check("t5_popped_head", {15'd0, add_load, add_a, add_b}, {15'd0, 1'b1, 16'h8080});
    push(8'hC8, 8'h64, 8'h2C, 1'b1);
    check("t5_full", {29'd0, fifo_count, in_ready}, {29'd0, 2'd2, 1'b0});
    push(8'h0F, 8'hF0, 8'hFF, 1'b0);
    in_valid = 1'b0;
    wait_idle();
    check("t5_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
